mem_loader: RTL and testbench
=============================

Name: mem_loader

Overview:
- Boot-time program/data loader that sits directly upstream of the byte-addressable 64 KiB data/instruction memory and drives its write port.
- Accepts a framed byte stream over a valid/ready interface and packs bytes little-endian into 32-bit words.
- Issues per-byte write strobes to the memory and checks an XOR checksum.
- Holds the CPU via cpu_hold while loading; the memory's read path is untouched.

Parameters:
- ADDR_W, 16, memory byte-address width; wraps modulo 2^ADDR_W.
- CHK_EN, 1, 1 = check trailing checksum byte; 0 = checksum byte is consumed but ignored.

Ports:
- clk  input  1  system clock, all state on posedge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse that begins a frame; ignored while busy
- in_valid  input  1  byte-stream valid
- in_data  input  8  byte-stream data
- in_ready  output  1  loader accepts in_data this cycle (transfer = in_valid & in_ready)
- mem_write  output  4  byte write enables to memory; bit k writes mem[addr+k]
- mem_addr  output  ADDR_W  byte address of lane 0
- mem_wdata  output  32  write data; lane k = bits [8k+7:8k]
- busy  output  1  frame in progress
- cpu_hold  output  1  equals busy; keeps CPU in reset/stall
- done  output  1  sticky: last frame finished; cleared by next accepted start
- err  output  1  sticky: last frame checksum mismatch; cleared by next accepted start

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0: in_ready, mem_write, mem_addr, mem_wdata, busy, cpu_hold, done, err. Internal counters, pack register and checksum also 0.
- Frame format, bytes in order: ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN data bytes, CSUM. CSUM = XOR of all data bytes (0x00 when LEN=0).
- State machine:
  - IDLE -> HDR on start.
  - HDR -> DATA after the 4th header byte if LEN>0; HDR -> CSUM if LEN=0.
  - DATA -> CSUM after byte number LEN is accepted.
  - CSUM -> DONE on the CSUM byte.
  - DONE -> IDLE after 1 cycle.
- in_ready: 1 in HDR, DATA and CSUM; 0 in IDLE and DONE. The loader never back-pressures inside a frame; a write in flight does not block the next byte.
- busy and cpu_hold: 1 from the cycle after start through DONE inclusive; 0 in IDLE.
- Packing: a lane counter (0..3) selects the byte lane. Each accepted data byte is placed in pack lane[cnt] and sets en[cnt].
- Word write is a registered single-cycle pulse in the cycle after the triggering byte is accepted. It is triggered by whichever comes first:
  - lane 3 filled: mem_write=4'b1111;
  - last data byte: mem_write=en (partial group), e.g. 4'b0011 for 2 bytes.
- Write pulse contents: mem_addr = group base; mem_wdata = pack; unused lanes 0.
- After each write pulse: base += bytes in group (mod 2^ADDR_W); lane counter and en clear; mem_write returns to 0 the following cycle.
- Addresses need not be aligned. The memory applies addr+k per lane; the wrap at 0xFFFF follows memory modulo arithmetic.
- Back-to-back: a byte accepted in the same cycle as a write pulse goes to lane 0 of the next group. The loader sustains 1 byte/cycle.
- Checksum is accumulated on data bytes only. In CSUM, if CHK_EN and byte != accumulator, err is set in DONE.
- done is set in DONE regardless of err.
- Data is written even when the checksum fails; err flags the frame, it does not roll it back.
- start while busy: ignored, no state change.
- in_valid while not in_ready: byte is not consumed.
- Reset mid-frame: immediate return to IDLE. Any pending partial group is discarded (never written); in-flight mem_write is forced to 0.

Decomposition:
- Shared package (loader_pkg):
  - state enum IDLE/HDR/DATA/CSUM/DONE;
  - constants HDR_BYTES=4, MEM_LANES=4, BE_FULL=4'b1111.
- One natural sub-module: word_packer. It holds the lane counter, pack register, enable mask and base address, and generates the registered write pulse; the top holds the FSM, header decode and checksum.

Test Plan:
- Aligned word: start; stream 00 01 08 00, then 11 22 33 44 55 66 77 88, then CSUM 0x88.
  -> Write A: mem_write=1111, mem_addr=0x0100, mem_wdata=0x44332211.
  -> Write B one word later: mem_addr=0x0104, mem_wdata=0x88776655.
  -> done=1, err=0; the memory reads back 0x44332211 at 0x0100.
- Partial tail: start; stream FE FF 03 00 AA BB CC, then CSUM 0xDD.
  -> mem_write=0111, mem_addr=0xFFFE, mem_wdata=0x00CCBBAA; the memory writes wrap to 0x0000.
- Bad checksum: frame as in the aligned-word scenario but CSUM 0x00.
  -> Both writes still occur; done=1, err=1.
  -> Next start clears done and err.
- LEN=0: stream 10 00 00 00, then 00.
  -> No mem_write pulse; done=1, err=0.
- Flow control: in_valid toggled every other cycle during DATA.
  -> Bytes are consumed only on valid; write contents match the aligned-word scenario; start pulsed mid-frame is ignored.
- Reset mid-frame: rst_n low after 2 of 4 data bytes.
  -> All outputs 0 asynchronously; no write issued.
  -> The following full frame loads correctly.

Source files
------------

// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the boot-time memory loader: FSM state encoding,
// frame header length and memory lane geometry.
// No ports (package).
// -----------------------------------------------------------------------------
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      DATA = 3'd2,
      CSUM = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam int                   HDR_BYTES = 4;
   localparam int                   MEM_LANES = 4;
   localparam int                   LANE_W    = $clog2(MEM_LANES);
   localparam logic [MEM_LANES-1:0] BE_FULL   = 4'b1111;

endpackage

// File: rtl/mem_loader_if.sv
// -----------------------------------------------------------------------------
// mem_loader_if
// Groups the loader's byte-stream input and memory write port.
//   in_valid/in_data/in_ready : valid/ready byte stream (host -> loader)
//   mem_write                 : per-lane byte write enables (loader -> memory)
//   mem_addr                  : byte address of lane 0
//   mem_wdata                 : write data, lane k = bits [8k+7:8k]
// Modports: slave  = loader side
//           master = host / memory side
// -----------------------------------------------------------------------------
interface mem_loader_if
   import loader_pkg::*;
#(
   parameter int ADDR_W = 16
);

   logic                   in_valid;
   logic [7:0]             in_data;
   logic                   in_ready;
   logic [MEM_LANES-1:0]   mem_write;
   logic [ADDR_W-1:0]      mem_addr;
   logic [8*MEM_LANES-1:0] mem_wdata;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output mem_write,
      output mem_addr,
      output mem_wdata
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  mem_write,
      input  mem_addr,
      input  mem_wdata
   );

endinterface

// File: rtl/word_packer.sv
// -----------------------------------------------------------------------------
// word_packer
// Packs accepted data bytes little-endian into a 32-bit word and emits a
// registered single-cycle write pulse when lane 3 fills or the frame's last
// data byte arrives. Tracks the running byte address of the current group.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_base_load  : load start address for a new frame (clears any group)
//   i_base       : frame start address
//   i_byte_vld   : a data byte is accepted this cycle
//   i_byte       : the data byte
//   i_last       : this byte is the frame's final data byte
//   o_mem_write  : byte write enables (pulse)
//   o_mem_addr   : group base address
//   o_mem_wdata  : packed group data, unused lanes zero
// -----------------------------------------------------------------------------
module word_packer
   import loader_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_base_load,
   input  logic [ADDR_W-1:0]      i_base,
   input  logic                   i_byte_vld,
   input  logic [7:0]             i_byte,
   input  logic                   i_last,
   output logic [MEM_LANES-1:0]   o_mem_write,
   output logic [ADDR_W-1:0]      o_mem_addr,
   output logic [8*MEM_LANES-1:0] o_mem_wdata
);

   logic [LANE_W-1:0]      r_cnt;
   logic [8*MEM_LANES-1:0] r_pack;
   logic [MEM_LANES-1:0]   r_en;
   logic [ADDR_W-1:0]      r_base;
   logic [MEM_LANES-1:0]   r_mem_write;
   logic [ADDR_W-1:0]      r_mem_addr;
   logic [8*MEM_LANES-1:0] r_mem_wdata;

   logic [8*MEM_LANES-1:0] w_pack_nxt;
   logic [MEM_LANES-1:0]   w_en_nxt;
   logic                   w_flush;
   logic [ADDR_W-1:0]      w_grp_bytes;

   // Pack/enable state as it would look with the incoming byte merged in.
   // The flush decision uses this merged view so that a byte completing the
   // group is written in the very next cycle.
   always_comb begin
      w_pack_nxt                         = r_pack;
      w_en_nxt                           = r_en;
      w_pack_nxt[{r_cnt, 3'b000} +: 8]   = i_byte;
      w_en_nxt[r_cnt]                    = 1'b1;
      w_flush                            = i_byte_vld && ((w_en_nxt == BE_FULL) || i_last);
      w_grp_bytes                        = ADDR_W'(r_cnt) + ADDR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_pack      <= '0;
         r_en        <= '0;
         r_base      <= '0;
         r_mem_write <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         // Write enables are a one-cycle pulse; address/data hold afterwards.
         r_mem_write <= '0;
         if (i_base_load) begin
            r_base <= i_base;
            r_cnt  <= '0;
            r_en   <= '0;
            r_pack <= '0;
         end else if (i_byte_vld) begin
            if (w_flush) begin
               r_mem_write <= w_en_nxt;
               r_mem_addr  <= r_base;
               r_mem_wdata <= w_pack_nxt;
               // Address advances by the bytes actually written; wraps mod 2^ADDR_W.
               r_base      <= r_base + w_grp_bytes;
               r_cnt       <= '0;
               r_en        <= '0;
               r_pack      <= '0;
            end else begin
               r_pack <= w_pack_nxt;
               r_en   <= w_en_nxt;
               r_cnt  <= r_cnt + LANE_W'(1);
            end
         end
      end
   end

   assign o_mem_write = r_mem_write;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;

endmodule

// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
// Boot-time loader: parses a framed byte stream
//   ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN data bytes, CSUM
// writes the data bytes into byte-addressable memory through word_packer,
// checks the XOR checksum and holds the CPU while a frame is in progress.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : pulse that begins a frame (ignored unless idle)
//   bus        : stream input + memory write port (slave modport)
//   busy       : frame in progress
//   cpu_hold   : same as busy
//   done       : sticky, last frame finished
//   err        : sticky, last frame had a checksum mismatch
// -----------------------------------------------------------------------------
module mem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter bit CHK_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   mem_loader_if.slave  bus,
   output logic         busy,
   output logic         cpu_hold,
   output logic         done,
   output logic         err
);

   localparam logic [1:0] HDR_LAST = 2'(HDR_BYTES - 1);

   state_t      r_state;
   state_t      w_state_nxt;

   logic [1:0]  r_hdr_cnt;
   logic [15:0] r_addr;
   logic [7:0]  r_len_lo;
   logic [15:0] r_remain;
   logic [7:0]  r_csum;
   logic        r_done;
   logic        r_err;

   logic        w_in_ready;
   logic        w_xfer;
   logic        w_start_acc;
   logic        w_hdr_byte;
   logic        w_hdr_last;
   logic [15:0] w_len_full;
   logic        w_data_byte;
   logic        w_data_last;
   logic        w_csum_byte;

   logic [MEM_LANES-1:0]   w_mem_write;
   logic [ADDR_W-1:0]      w_mem_addr;
   logic [8*MEM_LANES-1:0] w_mem_wdata;

   // The loader never back-pressures inside a frame: ready depends on state only.
   assign w_in_ready  = (r_state == HDR) || (r_state == DATA) || (r_state == CSUM);
   assign w_xfer      = bus.in_valid && w_in_ready;
   assign w_start_acc = (r_state == IDLE) && start;
   assign w_hdr_byte  = (r_state == HDR) && w_xfer;
   assign w_hdr_last  = w_hdr_byte && (r_hdr_cnt == HDR_LAST);
   // On the final header byte, LEN_HI is still on the bus.
   assign w_len_full  = {bus.in_data, r_len_lo};
   assign w_data_byte = (r_state == DATA) && w_xfer;
   assign w_data_last = w_data_byte && (r_remain == 16'd1);
   assign w_csum_byte = (r_state == CSUM) && w_xfer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (start)       w_state_nxt = HDR;
         HDR:  if (w_hdr_last)  w_state_nxt = (w_len_full == 16'd0) ? CSUM : DATA;
         DATA: if (w_data_last) w_state_nxt = CSUM;
         CSUM: if (w_csum_byte) w_state_nxt = DONE;
         DONE:                  w_state_nxt = IDLE;
         default:               w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hdr_cnt <= '0;
         r_addr    <= '0;
         r_len_lo  <= '0;
         r_remain  <= '0;
         r_csum    <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (w_start_acc) begin
            r_hdr_cnt <= '0;
            r_remain  <= '0;
            r_csum    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
         end
         if (w_hdr_byte) begin
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
            case (r_hdr_cnt)
               2'd0: r_addr[7:0]  <= bus.in_data;
               2'd1: r_addr[15:8] <= bus.in_data;
               2'd2: r_len_lo     <= bus.in_data;
               2'd3: r_remain     <= w_len_full;
               default: ;
            endcase
         end
         if (w_data_byte) begin
            r_csum   <= r_csum ^ bus.in_data;
            r_remain <= r_remain - 16'd1;
         end
         // Flags update on the CSUM byte so they are visible from DONE onward.
         if (w_csum_byte) begin
            r_done <= 1'b1;
            r_err  <= CHK_EN && (bus.in_data != r_csum);
         end
      end
   end

   // The address is complete by the last header byte (ADDR_HI arrived earlier).
   word_packer #(
      .ADDR_W (ADDR_W)
   ) u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_base_load (w_hdr_last),
      .i_base      (ADDR_W'(r_addr)),
      .i_byte_vld  (w_data_byte),
      .i_byte      (bus.in_data),
      .i_last      (w_data_last),
      .o_mem_write (w_mem_write),
      .o_mem_addr  (w_mem_addr),
      .o_mem_wdata (w_mem_wdata)
   );

   assign bus.in_ready  = w_in_ready;
   assign bus.mem_write = w_mem_write;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;

   assign busy     = (r_state != IDLE);
   assign cpu_hold = busy;
   assign done     = r_done;
   assign err      = r_err;

endmodule

// File: tb/tb_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_loader
// Self-checking bench for mem_loader: directed frames from the test plan plus
// randomized frames, compared against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_loader;

   typedef struct packed {
      logic [3:0]  be;
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, cpu_hold, done, err;

   int n_tests = 0;
   int n_fail  = 0;

   wr_t        obs_q[$];
   logic [7:0] fq[$];
   logic [7:0] tb_mem [0:65535];

   always #5 clk = ~clk;

   mem_loader_if #(.ADDR_W(16)) bus();

   mem_loader #(
      .ADDR_W (16),
      .CHK_EN (1'b1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bus      (bus.slave),
      .busy     (busy),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory model behind the write port: lane k lands at addr+k mod 64 KiB.
   always @(negedge clk) begin
      if (bus.mem_write != 4'b0000) begin
         obs_q.push_back({bus.mem_write, bus.mem_addr, bus.mem_wdata});
         for (int k = 0; k < 4; k++)
            if (bus.mem_write[k]) tb_mem[16'(bus.mem_addr + 16'(k))] = bus.mem_wdata[8*k +: 8];
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int guard;
      int idle_n;
      idle_n = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (idle_n) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("ready_timeout", {63'b0, bus.in_ready}, 64'd1);
      else @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
   endtask

   task automatic pulse_start(input string tag);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy"},     {63'b0, busy},         64'd1);
      check({tag, "_hold"},     {63'b0, cpu_hold},     64'd1);
      check({tag, "_done_clr"}, {63'b0, done},         64'd0);
      check({tag, "_err_clr"},  {63'b0, err},          64'd0);
      check({tag, "_ready"},    {63'b0, bus.in_ready}, 64'd1);
   endtask

   // Sends one full frame carrying fq and checks writes, flags and memory.
   task automatic run_frame(input string tag, input logic [15:0] addr, input logic [7:0] csum,
                            input int gap, input bit mid_start);
      wr_t        exp_q[$];
      wr_t        w;
      logic [7:0] acc;
      int         len;
      int         i;
      int         n;
      bit         exp_err;
      len = fq.size();
      acc = 8'h00;
      foreach (fq[j]) acc ^= fq[j];
      exp_err = (csum != acc);
      // Reference: consecutive groups of up to four bytes starting at addr.
      i = 0;
      while (i < len) begin
         n = (len - i > 4) ? 4 : len - i;
         w.be   = 4'((1 << n) - 1);
         w.addr = addr + 16'(i);
         w.data = '0;
         for (int k = 0; k < n; k++) w.data[8*k +: 8] = fq[i+k];
         exp_q.push_back(w);
         i += n;
      end
      obs_q.delete();
      pulse_start(tag);
      send_byte(addr[7:0], gap);
      send_byte(addr[15:8], gap);
      send_byte(8'(len), gap);
      send_byte(8'(len >> 8), gap);
      for (int j = 0; j < len; j++) begin
         if (mid_start && j == 2) start = 1'b1;
         send_byte(fq[j], gap);
         if (start) begin
            start = 1'b0;
            check({tag, "_busy_midstart"}, {63'b0, busy}, 64'd1);
         end
      end
      send_byte(csum, gap);
      check({tag, "_done"},      {63'b0, done}, 64'd1);
      check({tag, "_err"},       {63'b0, err},  {63'b0, exp_err});
      check({tag, "_busy_done"}, {63'b0, busy}, 64'd1);
      @(negedge clk);
      check({tag, "_busy_idle"}, {63'b0, busy},     64'd0);
      check({tag, "_hold_idle"}, {63'b0, cpu_hold}, 64'd0);
      repeat (2) @(negedge clk);
      check({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++)
         check({tag, "_wr"}, 64'(obs_q[j]), 64'(exp_q[j]));
      for (int j = 0; j < len; j++)
         check({tag, "_mem"}, 64'(tb_mem[addr + 16'(j)]), 64'(fq[j]));
   endtask

   task automatic load_aligned();
      fq.delete();
      for (int j = 0; j < 8; j++) fq.push_back(8'(8'h11 * (j + 1)));
   endtask

   initial begin
      logic [15:0] a;
      logic [7:0]  cs;
      int          len;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      rst_n = 1'b0;
      #12;
      check("rst_ready", {63'b0, bus.in_ready}, 64'd0);
      check("rst_wr",    64'(bus.mem_write),    64'd0);
      check("rst_addr",  64'(bus.mem_addr),     64'd0);
      check("rst_wdata", 64'(bus.mem_wdata),    64'd0);
      check("rst_busy",  {63'b0, busy},         64'd0);
      check("rst_hold",  {63'b0, cpu_hold},     64'd0);
      check("rst_done",  {63'b0, done},         64'd0);
      check("rst_err",   {63'b0, err},          64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Aligned words
      load_aligned();
      run_frame("aligned", 16'h0100, 8'h88, 0, 1'b0);
      check("aligned_rd", 64'({tb_mem[16'h0103], tb_mem[16'h0102], tb_mem[16'h0101], tb_mem[16'h0100]}),
            64'h44332211);

      // Partial tail with address wrap
      fq.delete();
      fq.push_back(8'hAA); fq.push_back(8'hBB); fq.push_back(8'hCC);
      run_frame("tail", 16'hFFFE, 8'hDD, 0, 1'b0);
      check("tail_wrap", 64'(tb_mem[16'h0000]), 64'hCC);

      // Bad checksum: data still written, err flagged
      load_aligned();
      run_frame("badcs", 16'h0100, 8'h00, 0, 1'b0);

      // LEN = 0 (its start also clears the previous err/done)
      fq.delete();
      run_frame("len0", 16'h0010, 8'h00, 0, 1'b0);

      // Flow control with a start pulse in the middle of the frame
      load_aligned();
      run_frame("flow", 16'h0100, 8'h88, 1, 1'b1);

      // Reset mid-frame
      fq.delete();
      for (int j = 0; j < 4; j++) fq.push_back(8'($urandom));
      obs_q.delete();
      pulse_start("rstmid");
      send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h00, 0);
      send_byte(fq[0], 0); send_byte(fq[1], 0);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_ready", {63'b0, bus.in_ready}, 64'd0);
      check("rstmid_wr",    64'(bus.mem_write),    64'd0);
      check("rstmid_addr",  64'(bus.mem_addr),     64'd0);
      check("rstmid_wdata", 64'(bus.mem_wdata),    64'd0);
      check("rstmid_busy",  {63'b0, busy},         64'd0);
      check("rstmid_hold",  {63'b0, cpu_hold},     64'd0);
      check("rstmid_done",  {63'b0, done},         64'd0);
      check("rstmid_err",   {63'b0, err},          64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rstmid_nwr", 64'(obs_q.size()), 64'd0);
      load_aligned();
      run_frame("postrst", 16'h0200, 8'h88, 0, 1'b0);

      // Randomized frames
      for (int f = 0; f < 12; f++) begin
         a   = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
         len = $urandom_range(0, 13);
         fq.delete();
         cs = 8'h00;
         for (int j = 0; j < len; j++) begin
            fq.push_back(8'($urandom));
            cs ^= fq[j];
         end
         if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
         run_frame("rand", a, cs, 2, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
